// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared sizing constants and word type for the 16x4 RAM
package ram_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/ram_4bit_rw_array.sv
// rtl/ram_4bit_rw_array.sv - reset-clearable register file with write enable and async read port
module ram_4bit_rw_array
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Storage: cleared by reset, written only when we_i is a definite 1
  // (an unknown enable falls through to "no write" so contents stay intact).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_4bit_rw.sv
// rtl/ram_4bit_rw.sv - 16x4 single-port RAM with registered read data
module ram_4bit_rw
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rw,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] data_out_d;

  ram_4bit_rw_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (rw),
    .addr_i (address),
    .wdata_i(data_in),
    .rdata_o(rdata)
  );

  // Output next-state: writes hold the previous read value; anything else
  // (including an unknown rw) is treated as a read of the addressed word.
  always_comb begin
    data_out_d = rdata;
    if (rw) begin
      data_out_d = data_out_q;
    end
  end

  // Read data register, cleared asynchronously with the storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram_4bit_rw.sv
// tb/tb_ram_4bit_rw.sv - self-checking bench for ram_4bit_rw
module tb_ram_4bit_rw;
  import ram_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] address;
  logic [3:0] data_in;
  logic       rw;
  logic [3:0] data_out;

  int n_checks;
  int n_fail;

  word_t model_mem [16];
  word_t model_out;

  ram_4bit_rw dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .address (address),
    .data_in (data_in),
    .rw      (rw),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain array plus the last value read.
  always @(negedge rst_n) begin
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_out = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (rw) model_mem[address] = data_in;
      else    model_out = model_mem[address];
    end
  end

  // Every falling edge the registered output must equal the model.
  always @(negedge clk) begin
    check("model_cmp", data_out, model_out);
  end

  task automatic op(input logic w, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    #1;
    rw = w; address = a; data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", data_out, 4'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rw       = 1'b0;
    address  = '0;
    data_in  = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_out = '0;
    #2;
    check("por_reset", data_out, 4'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Arbitrary contents, then reset between edges; all words must read 0.
    for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 4'($urandom_range(1, 15)));
    op(1'b0, 4'd5, 4'h0);
    async_reset_pulse();
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 4'(i), 4'h0);
      check("reset_read", data_out, 4'h0);
    end

    // Sweep: word a holds a+2 mod 16.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i + 2);
      op(1'b1, 4'(i), v);
      op(1'b0, 4'(i), 4'h0);
      check("sweep", data_out, v);
    end
    op(1'b0, 4'd13, 4'h0); check("wrap13", data_out, 4'hF);
    op(1'b0, 4'd14, 4'h0); check("wrap14", data_out, 4'h0);
    op(1'b0, 4'd15, 4'h0); check("wrap15", data_out, 4'h1);

    // A write leaves data_out holding the previous read.
    op(1'b0, 4'd3, 4'h0);  check("read3", data_out, 4'h5);
    op(1'b1, 4'd7, 4'hA);  check("write_hold", data_out, 4'h5);
    op(1'b0, 4'd7, 4'h0);  check("read7", data_out, 4'hA);

    // Overwrite leaves neighbours alone.
    op(1'b1, 4'd9, 4'h3);
    op(1'b1, 4'd9, 4'hC);
    op(1'b0, 4'd9, 4'h0);  check("overwrite9", data_out, 4'hC);
    op(1'b0, 4'd8, 4'h0);  check("neighbour8", data_out, 4'hA);
    op(1'b0, 4'd10, 4'h0); check("neighbour10", data_out, 4'hC);

    // Back-to-back write then read of the same word.
    op(1'b1, 4'd0, 4'h6);
    op(1'b0, 4'd0, 4'h0);  check("back_to_back", data_out, 4'h6);

    // Randomized traffic checked by the model on every cycle.
    for (int n = 0; n < 400; n++) begin
      op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Fill everything, reset mid-run, all words back to 0.
    for (int i = 0; i < 16; i++) op(1'b1, 4'(i), 4'(15 - i));
    op(1'b0, 4'd2, 4'h0);  check("fill_read2", data_out, 4'hD);
    async_reset_pulse();
    for (int i = 0; i < 16; i++) begin
      op(1'b0, 4'(i), 4'h0);
      check("post_reset_read", data_out, 4'h0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
